// File: rtl/button_conditioner_pkg.sv
// button_conditioner_pkg: repeat-FSM state type and default parameters shared by input blocks
package button_conditioner_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        REPEAT
    } rep_state_e;

    localparam int DEF_NUM_BTN       = 5;
    localparam int DEF_DB_DEPTH      = 4;
    localparam int DEF_HOLD_CYCLES   = 1000;
    localparam int DEF_REPEAT_CYCLES = 250;
    localparam int DEF_CNT_W         = 16;

endpackage

// File: rtl/button_conditioner_if.sv
// button_conditioner_if: raw pins in, conditioned button events out
interface button_conditioner_if
    import button_conditioner_pkg::*;
#(
    parameter int NUM_BTN = DEF_NUM_BTN
);

    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_press;
    logic [NUM_BTN-1:0] btn_release;
    logic [NUM_BTN-1:0] btn_repeat;

    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  btn_repeat
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_press,
        output btn_release,
        output btn_repeat
    );

endinterface

// File: rtl/btn_channel.sv
// btn_channel: synchronizer, shift-register debouncer, edge pulses and hold-to-repeat for one button
module btn_channel
    import button_conditioner_pkg::*;
#(
    parameter int DB_DEPTH      = DEF_DB_DEPTH,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic repeat_o
);

    logic                s1_q, s2_q;
    logic [DB_DEPTH-1:0] sh_q, sh_d;
    logic                level_q, level_d;
    logic                press_q, press_d;
    logic                release_q, release_d;
    logic                repeat_q, repeat_d;
    rep_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    always_comb begin
        sh_d      = {sh_q[DB_DEPTH-2:0], s2_q};
        level_d   = (&sh_q) ? 1'b1 : (~|sh_q) ? 1'b0 : level_q;
        press_d   = level_d & ~level_q;
        release_d = ~level_d & level_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        repeat_d  = 1'b0;
        // release wins over a repeat falling due on the same edge
        if (release_d) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (press_d) begin
                        state_d = HOLD;
                        cnt_d   = '0;
                    end
                end
                HOLD: begin
                    if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
                        state_d  = REPEAT;
                        cnt_d    = '0;
                        repeat_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                REPEAT: begin
                    repeat_d = (cnt_q == CNT_W'(REPEAT_CYCLES - 1));
                    cnt_d    = repeat_d ? '0 : cnt_q + 1'b1;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            sh_q      <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            repeat_q  <= 1'b0;
            state_q   <= IDLE;
            cnt_q     <= '0;
        end else begin
            s1_q      <= raw_i;
            s2_q      <= s1_q;
            sh_q      <= sh_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            repeat_q  <= repeat_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign repeat_o  = repeat_q;

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: NUM_BTN independent button channels behind one interface
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int NUM_BTN       = DEF_NUM_BTN,
    parameter int DB_DEPTH      = DEF_DB_DEPTH,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input logic                 clk,
    input logic                 rst,
    button_conditioner_if.slave bus
);

    logic [NUM_BTN-1:0] level, press, release_p, repeat_p;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        btn_channel #(
            .DB_DEPTH     (DB_DEPTH),
            .HOLD_CYCLES  (HOLD_CYCLES),
            .REPEAT_CYCLES(REPEAT_CYCLES),
            .CNT_W        (CNT_W)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .raw_i    (bus.btn_raw[i]),
            .level_o  (level[i]),
            .press_o  (press[i]),
            .release_o(release_p[i]),
            .repeat_o (repeat_p[i])
        );
    end

    assign bus.btn_level   = level;
    assign bus.btn_press   = press;
    assign bus.btn_release = release_p;
    assign bus.btn_repeat  = repeat_p;

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: table-driven per-cycle vectors plus a mid-hold reset sequence
module tb_button_conditioner;

    localparam int NB = 2;

    typedef struct {
        logic [1:0] raw;
        logic       rst;
        logic [1:0] lvl;
        logic [1:0] prs;
        logic [1:0] rel;
        logic [1:0] rpt;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    button_conditioner_if #(.NUM_BTN(NB)) bif ();

    button_conditioner #(
        .NUM_BTN      (NB),
        .DB_DEPTH     (4),
        .HOLD_CYCLES  (8),
        .REPEAT_CYCLES(3),
        .CNT_W        (16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bif.slave)
    );

    function automatic vec_t mk(input logic [1:0] raw, input logic r, input logic [1:0] lvl,
                                input logic [1:0] prs, input logic [1:0] rel, input logic [1:0] rpt);
        vec_t v;
        v.raw = raw;
        v.rst = r;
        v.lvl = lvl;
        v.prs = prs;
        v.rel = rel;
        v.rpt = rpt;
        return v;
    endfunction

    // drive one cycle of inputs, then check the outputs produced by that edge
    task automatic step(input vec_t v, input string name);
        bif.btn_raw = v.raw;
        rst         = v.rst;
        @(posedge clk);
        #1;
        tests++;
        if ({bif.btn_level, bif.btn_press, bif.btn_release, bif.btn_repeat} !==
            {v.lvl, v.prs, v.rel, v.rpt}) begin
            fails++;
            $display("FAIL %s: got lvl=%b prs=%b rel=%b rpt=%b, want lvl=%b prs=%b rel=%b rpt=%b",
                     name, bif.btn_level, bif.btn_press, bif.btn_release, bif.btn_repeat,
                     v.lvl, v.prs, v.rel, v.rpt);
        end
    endtask

    initial begin
        logic [6:0] pat;
        pat = 7'b0011011;
        bif.btn_raw = '0;
        rst = 1'b1;

        // reset with both pins high, then press on both at +7, released before the first repeat
        tbl.push_back(mk(2'b11, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(2'b11, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00));
        for (int j = 0; j < 6; j++) tbl.push_back(mk(2'b11, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(2'b11, 1'b0, 2'b11, 2'b11, 2'b00, 2'b00));
        for (int j = 7; j < 13; j++) tbl.push_back(mk(2'b00, 1'b0, 2'b11, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(2'b00, 1'b0, 2'b00, 2'b00, 2'b11, 2'b00));
        tbl.push_back(mk(2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00));

        // ch0 clean press, held: repeats at P+8,11,14,17,20; release lands on due repeat at P+23
        for (int k = 0; k < 32; k++)
            tbl.push_back(mk(2'(k < 23), 1'b0, 2'(k >= 6 && k < 29), 2'(k == 6), 2'(k == 29),
                             2'(k == 14 || k == 17 || k == 20 || k == 23 || k == 26)));

        // ch0 bounce 1,1,0,1,1,0,0 never reaches four equal samples
        for (int k = 0; k < 15; k++)
            tbl.push_back(mk((k < 7) ? {1'b0, pat[k]} : 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00));

        for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("vec%0d", i));

        // both channels pressed together, reset at P+5, fresh press after full latency
        for (int j = 0; j < 6; j++) step(mk(2'b11, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00), "both_latency");
        step(mk(2'b11, 1'b0, 2'b11, 2'b11, 2'b00, 2'b00), "both_press");
        for (int j = 7; j < 11; j++) step(mk(2'b11, 1'b0, 2'b11, 2'b00, 2'b00, 2'b00), "both_hold");
        step(mk(2'b11, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00), "mid_hold_rst");
        for (int j = 0; j < 6; j++) step(mk(2'b11, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00), "post_rst_quiet");
        step(mk(2'b11, 1'b0, 2'b11, 2'b11, 2'b00, 2'b00), "fresh_press");
        for (int j = 1; j < 8; j++) step(mk(2'b11, 1'b0, 2'b11, 2'b00, 2'b00, 2'b00), "fresh_hold");
        step(mk(2'b11, 1'b0, 2'b11, 2'b00, 2'b00, 2'b11), "fresh_repeat");
        step(mk(2'b11, 1'b0, 2'b11, 2'b00, 2'b00, 2'b00), "fresh_gap");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
